dm_readback: RTL and testbench

//  Receive-side counterpart of the display manager. Watches the multiplexed 7-seg bus (an, dec_ddp),

---
 rtl/dm_readback_pkg.sv | 26 ++
 rtl/dm_readback_seg7_to_bcd.sv | 26 ++
 rtl/dm_readback.sv | 87 ++++++++
 tb/tb_dm_readback.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dm_readback_pkg.sv
// dm_readback_pkg: segment codes, FSM states and digit indices shared by the 7-seg readback monitor
package dm_readback_pkg;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic [1:0] {SCAN, ASM, PUB} state_t;
  localparam int NUM_DIGITS = 8;
  localparam int D1_IDX     = 0;
  localparam int D2_IDX     = 1;
  localparam int D3_IDX     = 2;
  localparam int D4_IDX     = 3;
  localparam int MODULO_IDX = 5;
  localparam int PROG_IDX   = 7;
  function automatic logic [2:0] low_idx(input logic [7:0] an);
    low_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (!an[i]) low_idx = 3'(i);
  endfunction
endpackage

// File: rtl/dm_readback_seg7_to_bcd.sv
// seg7_to_bcd: active-low a..g pattern to BCD; blank reads as 0, unknown patterns flag bad
module seg7_to_bcd
  import dm_readback_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       bad
);
  always_comb begin
    bcd = '0;
    bad = 1'b0;
    case (seg)
      SEG_0, SEG_BLANK: bcd = 4'd0;
      SEG_1: bcd = 4'd1;
      SEG_2: bcd = 4'd2;
      SEG_3: bcd = 4'd3;
      SEG_4: bcd = 4'd4;
      SEG_5: bcd = 4'd5;
      SEG_6: bcd = 4'd6;
      SEG_7: bcd = 4'd7;
      SEG_8: bcd = 4'd8;
      SEG_9: bcd = 4'd9;
      default: bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/dm_readback.sv
// dm_readback: rebuilds data/modulo/prog from the multiplexed 7-seg bus.
// DM_READBACK_CHANGE_ONLY_EN: publish only when the rebuilt frame differs from the held outputs.
module dm_readback
  import dm_readback_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  dec_ddp,
  output logic [15:0] data_o,
  output logic [1:0]  modulo_o,
  output logic [2:0]  prog_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        stale_o
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [7:0] an_m, an_s, an_p, dec_m, dec_s, seen, bad, smask;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic [3:0] digit [NUM_DIGITS];
  logic [3:0] bcd;
  logic [2:0] idx, step;
  logic [15:0] acc;
  logic bcd_bad, change, onehot, sample, publish, unused_dp;
  state_t state, state_n;
  seg7_to_bcd u_dec (.seg(dec_s[7:1]), .bcd(bcd), .bad(bcd_bad));
  assign unused_dp = dec_s[0];
  assign change  = an_s != an_p;
  assign onehot  = (~an_s & (~an_s - 8'd1)) == 8'd0 && an_s != 8'hFF;
  assign idx     = low_idx(an_s);
  assign sample  = state == SCAN && onehot && !change && scnt == SW'(SETTLE - 1);
  assign smask   = sample ? 8'd1 << idx : 8'd0;
  assign stale_o = tcnt == TW'(TIMEOUT);
`ifdef DM_READBACK_CHANGE_ONLY_EN
  logic first;
  assign publish = first || {acc, digit[MODULO_IDX][1:0], digit[PROG_IDX][2:0], |bad}
                            != {data_o, modulo_o, prog_o, err_o};
`else
  assign publish = 1'b1;
`endif
  always_comb begin
    state_n = SCAN;
    if (state == SCAN) state_n = (seen | smask) == 8'hFF ? ASM : SCAN;
    else if (state == ASM) state_n = step == 3'd3 ? PUB : ASM;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {an_m, an_s, an_p, dec_m, dec_s} <= {5{8'hFF}};
      {seen, bad, scnt, tcnt, step, acc} <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
      {data_o, modulo_o, prog_o, valid_o, err_o} <= '0;
      state <= SCAN;
`ifdef DM_READBACK_CHANGE_ONLY_EN
      first <= 1'b1;
`endif
    end else begin
      {an_s, an_m} <= {an_m, an};
      {dec_s, dec_m} <= {dec_m, dec_ddp};
      an_p <= an_s;
      scnt <= change ? '0 : scnt == SW'(SETTLE) ? scnt : scnt + 1'b1;
      tcnt <= change ? '0 : stale_o ? tcnt : tcnt + 1'b1;
      state <= state_n;
      if (sample) digit[idx] <= bcd;
      seen <= state == PUB ? 8'd0 : seen | smask;
      bad <= state == PUB ? 8'd0 : (bad & ~smask) | (bcd_bad ? smask : 8'd0);
      step <= state == ASM ? step + 3'd1 : 3'd0;
      // most significant digit enters first: d4, d3, d2, d1
      acc <= state == ASM ? acc * 16'd10 + {12'd0, digit[3'(D4_IDX) - step]} : 16'd0;
      valid_o <= 1'b0;
      if (state == PUB && publish) begin
        data_o   <= acc;
        modulo_o <= digit[MODULO_IDX][1:0];
        prog_o   <= digit[PROG_IDX][2:0];
        err_o    <= |bad;
        valid_o  <= 1'b1;
`ifdef DM_READBACK_CHANGE_ONLY_EN
        first <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_dm_readback.sv
// tb_dm_readback: randomized frames on the 7-seg bus checked against a digit-level value model
module tb_dm_readback;
  localparam int SETTLE = 4, TIMEOUT = 200, DWELL = SETTLE + 6;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] an = 8'hFF, dec_ddp = 8'hFF;
  logic [15:0] data_o;
  logic [1:0] modulo_o;
  logic [2:0] prog_o;
  logic valid_o, err_o, stale_o;
  int passed = 0, total = 0, vcnt = 0;
  logic [15:0] h_d = '0;
  logic [1:0] h_m = '0;
  logic [2:0] h_p = '0;
  logic h_e = 1'b0;
  bit first_m = 1'b1;
  // lit-segment masks a..g; code 10 = blank, code 11 = "-" (undecodable)
  logic [6:0] lit_tab [12] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
                               7'b0000000, 7'b0000001};

  dm_readback #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .an(an), .dec_ddp(dec_ddp), .data_o(data_o), .modulo_o(modulo_o),
    .prog_o(prog_o), .valid_o(valid_o), .err_o(err_o), .stale_o(stale_o));

  always #5 clk = ~clk;
  always @(negedge clk) if (valid_o === 1'b1) vcnt++;

  function automatic int val(input int code);
    return code < 10 ? code : 0;
  endfunction

  task automatic show(input int k, input int code, input int dwell);
    an = ~(8'd1 << k);
    dec_ddp = {~lit_tab[code], 1'($urandom)};
    repeat (dwell) @(negedge clk);
  endtask

  task automatic run_frame(input int c[8], input bit rev);
    int v0, e_d, k;
    logic [1:0] e_m;
    logic [2:0] e_p;
    logic e_e;
    bit pub;
    e_d = val(c[3]) * 1000 + val(c[2]) * 100 + val(c[1]) * 10 + val(c[0]);
    e_m = 2'(val(c[5]));
    e_p = 3'(val(c[7]));
    e_e = 1'b0;
    for (int i = 0; i < 8; i++) if (c[i] == 11) e_e = 1'b1;
    pub = 1'b1;
`ifdef DM_READBACK_CHANGE_ONLY_EN
    pub = first_m || {16'(e_d), e_m, e_p, e_e} != {h_d, h_m, h_p, h_e};
`endif
    v0 = vcnt;
    for (int j = 0; j < 8; j++) begin
      k = rev ? 7 - j : j;
      show(k, c[k], DWELL);
    end
    an = 8'hFF;
    repeat (20) @(negedge clk);
    if (pub) begin
      h_d = 16'(e_d);
      h_m = e_m;
      h_p = e_p;
      h_e = e_e;
      first_m = 1'b0;
    end
    total++; if (vcnt - v0 !== (pub ? 1 : 0)) $display("FAIL valid_count: got %0d want %0d", vcnt - v0, pub ? 1 : 0); else passed++;
    total++; if (data_o !== h_d) $display("FAIL data: got %0d want %0d", data_o, h_d); else passed++;
    total++; if (modulo_o !== h_m) $display("FAIL modulo: got %0d want %0d", modulo_o, h_m); else passed++;
    total++; if (prog_o !== h_p) $display("FAIL prog: got %0d want %0d", prog_o, h_p); else passed++;
    total++; if (err_o !== h_e) $display("FAIL err: got %0b want %0b", err_o, h_e); else passed++;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if ({data_o, modulo_o, prog_o} !== 21'd0) $display("FAIL reset_values: got %h want 0", {data_o, modulo_o, prog_o}); else passed++;
    total++; if ({valid_o, err_o, stale_o} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {valid_o, err_o, stale_o}); else passed++;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ({valid_o, stale_o} !== 2'b00) $display("FAIL post_reset_flags: got %b want 00", {valid_o, stale_o}); else passed++;
  endtask

  task automatic test_fixed;
    int c[8];
    c = '{4, 3, 2, 1, 0, 2, 0, 5};
    run_frame(c, 1'b0);
    c = '{9, 9, 9, 9, 9, 9, 9, 9};
    run_frame(c, 1'b1);
    c = '{10, 10, 10, 10, 10, 10, 10, 10};
    run_frame(c, 1'b0);
  endtask

  task automatic test_error;
    int c[8];
    c = '{8, 8, 11, 8, 8, 3, 8, 6};
    run_frame(c, 1'b0);
    c = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_frame(c, 1'b1);
  endtask

  task automatic test_random;
    int c[8];
    repeat (6) begin
      for (int i = 0; i < 8; i++) c[i] = int'($urandom_range(0, 11));
      run_frame(c, 1'($urandom));
    end
  endtask

  task automatic test_no_sample;
    int v0;
    v0 = vcnt;
    for (int k = 0; k < 8; k++) show(k, 11, 2);
    an = 8'hFC;
    dec_ddp = {~lit_tab[11], 1'b1};
    repeat (DWELL + 10) @(negedge clk);
    an = 8'hFF;
    repeat (20) @(negedge clk);
    total++; if (vcnt !== v0) $display("FAIL no_sample_valid: got %0d pulses want 0", vcnt - v0); else passed++;
    total++; if ({data_o, err_o} !== {h_d, h_e}) $display("FAIL no_sample_hold: got %h want %h", {data_o, err_o}, {h_d, h_e}); else passed++;
  endtask

  task automatic test_reset_asm;
    int c[8], v0;
    for (int i = 0; i < 8; i++) c[i] = int'($urandom_range(1, 9));
    for (int k = 0; k < 7; k++) show(k, c[k], DWELL);
    show(7, c[7], 8);
    rst = 1'b0;
    v0 = vcnt;
    repeat (3) @(negedge clk);
    total++; if ({data_o, modulo_o, prog_o} !== 21'd0) $display("FAIL asm_reset_values: got %h want 0", {data_o, modulo_o, prog_o}); else passed++;
    total++; if ({valid_o, err_o} !== 2'b00) $display("FAIL asm_reset_flags: got %b want 00", {valid_o, err_o}); else passed++;
    an = 8'hFF;
    dec_ddp = 8'hFF;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (vcnt !== v0) $display("FAIL asm_reset_valid: got %0d pulses want 0", vcnt - v0); else passed++;
    {h_d, h_m, h_p, h_e} = '0;
    first_m = 1'b1;
    for (int i = 0; i < 8; i++) c[i] = int'($urandom_range(0, 9));
    run_frame(c, 1'b0);
  endtask

  task automatic test_back_to_back;
    int c[8];
    c = '{7, 0, 5, 2, 1, 3, 4, 6};
    run_frame(c, 1'b0);
    run_frame(c, 1'b1);
  endtask

  task automatic test_stale;
    show(0, 1, 5);
    total++; if (stale_o !== 1'b0) $display("FAIL stale_early: got %b want 0", stale_o); else passed++;
    repeat (TIMEOUT / 2) @(negedge clk);
    total++; if (stale_o !== 1'b0) $display("FAIL stale_mid: got %b want 0", stale_o); else passed++;
    repeat (TIMEOUT) @(negedge clk);
    total++; if (stale_o !== 1'b1) $display("FAIL stale_set: got %b want 1", stale_o); else passed++;
    show(1, 2, 5);
    total++; if (stale_o !== 1'b0) $display("FAIL stale_clear: got %b want 0", stale_o); else passed++;
    an = 8'hFF;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_error;
    test_no_sample;
    test_random;
    test_reset_asm;
    test_back_to_back;
    test_stale;
    test_fixed;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
